aes_byte_feeder: RTL

//   Upstream stage of AES_encryption. Accepts one 128-bit key and one 128-bit plaintext block per

---
 rtl/aes_byte_feeder.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/aes_byte_feeder.sv
// -----------------------------------------------------------------------------
// aes_byte_feeder
//   Upstream stage of AES_encryption. Takes one key/plaintext pair per
//   valid/ready handshake into a pending buffer. Each pair moves to an active
//   buffer and is then streamed MSB byte first to the core's byte-serial
//   inputs. The core's ready rising edge completes the block. A timeout ends
//   the block if the core never answers.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   in_valid      producer has a key/block pair
//   in_ready      pending buffer empty (registered)
//   in_key        cipher key, [8*NBYTES-1 -: 8] sent first
//   in_block      plaintext, [8*NBYTES-1 -: 8] sent first
//   key_byte      key byte to the core (registered)
//   state_byte    plaintext byte to the core (registered)
//   enable        core enable (registered)
//   aes_ready     core ready; its rising edge in WAIT completes the block
//   busy          FSM not in IDLE (registered)
//   done          1-cycle pulse, block completed by aes_ready
//   timeout_err   1-cycle pulse, WAIT expired without aes_ready
//
// Parameters
//   NBYTES    bytes per block
//   LEAD_CYC  cycles of enable before the first byte
//   TIMEOUT   WAIT cycles before timeout_err, 0 disables the timeout
// -----------------------------------------------------------------------------
module aes_byte_feeder #(
    parameter int NBYTES   = 16,
    parameter int LEAD_CYC = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   in_key,
    input  logic [8*NBYTES-1:0]   in_block,
    output logic [7:0]            key_byte,
    output logic [7:0]            state_byte,
    output logic                  enable,
    input  logic                  aes_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err
);

    localparam int KW    = 8 * NBYTES;
    localparam int M1    = (NBYTES > LEAD_CYC) ? NBYTES : LEAD_CYC;
    localparam int M2    = (M1 > TIMEOUT) ? M1 : TIMEOUT;
    localparam int CNT_W = (M2 > 1) ? $clog2(M2) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SEND,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic                pend_full, pend_full_d;
    logic [KW-1:0]       pend_key, pend_blk;
    logic [KW-1:0]       act_key, act_blk, act_key_d, act_blk_d;
    logic                aes_ready_q;
    logic                accept, move, rise;
    logic                done_d, timeout_d;

    // Byte idx of a block, counting from the most significant byte.
    function automatic logic [7:0] byte_at(input logic [KW-1:0] data,
                                           input logic [CNT_W-1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx == CNT_W'(i)) begin
                b = data[8*(NBYTES-1-i) +: 8];
            end
        end
        return b;
    endfunction

    assign accept = in_valid && in_ready;
    assign rise   = aes_ready && !aes_ready_q;

    // Next-state logic. Outputs are decoded from the next state so that
    // they can be registered without adding a cycle of latency.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        act_key_d = act_key;
        act_blk_d = act_blk;
        move      = 1'b0;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        case (state)
            S_IDLE: begin
                if (pend_full) begin
                    move      = 1'b1;
                    act_key_d = pend_key;
                    act_blk_d = pend_blk;
                    cnt_d     = '0;
                    state_d   = (LEAD_CYC == 0) ? S_SEND : S_ARM;
                end
            end
            S_ARM: begin
                if (cnt == CNT_W'(LEAD_CYC - 1)) begin
                    state_d = S_SEND;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_SEND: begin
                if (cnt == CNT_W'(NBYTES - 1)) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_WAIT: begin
                cnt_d = cnt + CNT_W'(1);
                // A ready edge takes priority over a coincident timeout.
                if (rise) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else if ((TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1))) begin
                    state_d   = S_DONE;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pending buffer: a fresh accept wins over a move in the same cycle.
    always_comb begin
        pend_full_d = pend_full;
        if (accept) begin
            pend_full_d = 1'b1;
        end else if (move) begin
            pend_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            pend_full   <= 1'b0;
            pend_key    <= '0;
            pend_blk    <= '0;
            act_key     <= '0;
            act_blk     <= '0;
            aes_ready_q <= 1'b0;
            in_ready    <= 1'b1;
            key_byte    <= 8'h00;
            state_byte  <= 8'h00;
            enable      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            pend_full   <= pend_full_d;
            act_key     <= act_key_d;
            act_blk     <= act_blk_d;
            aes_ready_q <= aes_ready;
            if (accept) begin
                pend_key <= in_key;
                pend_blk <= in_block;
            end
            in_ready    <= !pend_full_d;
            enable      <= (state_d == S_ARM) || (state_d == S_SEND) || (state_d == S_WAIT);
            busy        <= (state_d != S_IDLE);
            done        <= done_d;
            timeout_err <= timeout_d;
            if (state_d == S_SEND) begin
                key_byte   <= byte_at(act_key_d, cnt_d);
                state_byte <= byte_at(act_blk_d, cnt_d);
            end else begin
                key_byte   <= 8'h00;
                state_byte <= 8'h00;
            end
        end
    end

endmodule
